// File: rtl/noc2_msg_assembler.sv
// NoC2 message assembler: gathers a header flit plus up to PAYLOAD_FLITS payload
// flits into one wide message and holds it for the L1.5 until it is consumed.

module noc2_msg_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        we,
  input  logic [63:0] din,
  output logic [63:0] dout
);
  logic [63:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr)     slot_d = '0;
    else if (we) slot_d = din;
  end

  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign dout = slot_q;
endmodule

module noc2_msg_assembler #(
  parameter int PAYLOAD_FLITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       noc2_in_val,
  input  logic [63:0]                noc2_in_data,
  output logic                       noc2_in_rdy,
  output logic                       msg_val,
  input  logic                       msg_rdy,
  output logic [63:0]                msg_header,
  output logic [64*PAYLOAD_FLITS-1:0] msg_data,
  output logic [7:0]                 msg_len,
  output logic                       msg_err
);
  typedef enum logic [1:0] {HDR, PAY, HOLD} state_e;

  localparam logic [8:0] MAX_LEN = 9'(PAYLOAD_FLITS);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  len_q, len_d;
  logic [63:0] hdr_q, hdr_d;
  logic        err_q, err_d;
  logic        slot_clr;
  logic [PAYLOAD_FLITS-1:0]       slot_we;
  logic [PAYLOAD_FLITS-1:0][63:0] slots;
  logic        xfer;
  logic [7:0]  in_len;

  assign xfer   = noc2_in_val && noc2_in_rdy;
  assign in_len = noc2_in_data[29:22];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    hdr_d    = hdr_q;
    err_d    = err_q;
    slot_clr = 1'b0;
    slot_we  = '0;
    case (state_q)
      HDR: if (xfer) begin
        hdr_d    = noc2_in_data;
        len_d    = in_len;
        cnt_d    = '0;
        slot_clr = 1'b1;
        if ({1'b0, in_len} > MAX_LEN) err_d = 1'b1;
        state_d  = (in_len == 8'd0) ? HOLD : PAY;
      end
      PAY: if (xfer) begin
        // Flits beyond the buffer still count toward len but land nowhere.
        for (int k = 0; k < PAYLOAD_FLITS; k++)
          if (cnt_q == 8'(k)) slot_we[k] = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if ({1'b0, cnt_q} + 9'd1 == {1'b0, len_q}) state_d = HOLD;
      end
      HOLD: if (msg_rdy) state_d = HDR;
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR;
      cnt_q   <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      hdr_q   <= hdr_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < PAYLOAD_FLITS; g++) begin : g_slot
    noc2_msg_slot u_slot (
      .clk  (clk),
      .rst  (rst),
      .clr  (slot_clr),
      .we   (slot_we[g]),
      .din  (noc2_in_data),
      .dout (slots[g])
    );
  end

  // Ready is a pure decode of the state flop, so msg_rdy never reaches it.
  assign noc2_in_rdy = (state_q != HOLD);
  assign msg_val     = (state_q == HOLD);
  assign msg_header  = hdr_q;
  assign msg_len     = len_q;
  assign msg_err     = err_q;
  assign msg_data    = slots;
endmodule

// File: tb/tb_noc2_msg_assembler.sv
// Directed bench for noc2_msg_assembler: drives on negedge / after posedge,
// samples on negedge against hand-computed expectations.

module tb_noc2_msg_assembler;
  localparam int P = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           noc2_in_val;
  logic [63:0]    noc2_in_data;
  logic           noc2_in_rdy;
  logic           msg_val;
  logic           msg_rdy;
  logic [63:0]    msg_header;
  logic [64*P-1:0] msg_data;
  logic [7:0]     msg_len;
  logic           msg_err;

  int checks = 0;
  int errors = 0;
  logic [P-1:0][63:0] exp;

  noc2_msg_assembler #(.PAYLOAD_FLITS(P)) dut (
    .clk          (clk),
    .rst          (rst),
    .noc2_in_val  (noc2_in_val),
    .noc2_in_data (noc2_in_data),
    .noc2_in_rdy  (noc2_in_rdy),
    .msg_val      (msg_val),
    .msg_rdy      (msg_rdy),
    .msg_header   (msg_header),
    .msg_data     (msg_data),
    .msg_len      (msg_len),
    .msg_err      (msg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_hdr(input logic [7:0] len);
    return 64'hABCD_0000_0000_0000 | (64'(len) << 22);
  endfunction

  // Presents one flit, waiting (bounded) for ready; val drops right after the edge.
  task automatic send(input logic [63:0] d);
    int w;
    @(negedge clk);
    w = 0;
    while (!noc2_in_rdy && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (noc2_in_rdy !== 1'b1) begin
      errors++; $display("FAIL send_rdy_timeout got rdy=%0b want 1", noc2_in_rdy);
    end
    noc2_in_val  = 1'b1;
    noc2_in_data = d;
    @(posedge clk);
    #1 noc2_in_val = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; msg_rdy = 1'b0;
    noc2_in_val = 1'b1; noc2_in_data = mk_hdr(8'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; noc2_in_val = 1'b0;
    checks++; if (msg_val !== 1'b0)    begin errors++; $display("FAIL reset_val got %0b want 0", msg_val); end
    checks++; if (msg_header !== 64'h0) begin errors++; $display("FAIL reset_hdr got %h want 0", msg_header); end
    checks++; if (msg_data !== '0)     begin errors++; $display("FAIL reset_data got %h want 0", msg_data); end
    checks++; if (msg_len !== 8'h0)    begin errors++; $display("FAIL reset_len got %h want 0", msg_len); end
    checks++; if (msg_err !== 1'b0)    begin errors++; $display("FAIL reset_err got %0b want 0", msg_err); end
    checks++; if (noc2_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b want 1", noc2_in_rdy); end
  endtask

  task automatic test_zero_len;
    msg_rdy = 1'b1;
    send(64'h0);
    @(negedge clk);
    checks++; if (msg_val !== 1'b1)     begin errors++; $display("FAIL zlen_val got %0b want 1", msg_val); end
    checks++; if (msg_len !== 8'h0)     begin errors++; $display("FAIL zlen_len got %h want 0", msg_len); end
    checks++; if (msg_data !== '0)      begin errors++; $display("FAIL zlen_data got %h want 0", msg_data); end
    checks++; if (noc2_in_rdy !== 1'b0) begin errors++; $display("FAIL zlen_rdy got %0b want 0", noc2_in_rdy); end
    @(negedge clk);
    checks++; if (msg_val !== 1'b0)     begin errors++; $display("FAIL zlen_val_drop got %0b want 0", msg_val); end
    checks++; if (noc2_in_rdy !== 1'b1) begin errors++; $display("FAIL zlen_rdy_back got %0b want 1", noc2_in_rdy); end
    msg_rdy = 1'b0;
  endtask

  task automatic test_three_flit;
    exp = '0;
    exp[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    exp[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    exp[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    send(mk_hdr(8'd3));
    send(exp[0]);
    send(exp[1]);
    @(negedge clk);
    checks++; if (msg_val !== 1'b0) begin errors++; $display("FAIL three_early_val got %0b want 0", msg_val); end
    send(exp[2]);
    @(negedge clk);
    checks++; if (msg_val !== 1'b1)       begin errors++; $display("FAIL three_val got %0b want 1", msg_val); end
    checks++; if (msg_data !== exp)       begin errors++; $display("FAIL three_data got %h want %h", msg_data, exp); end
    checks++; if (msg_len !== 8'd3)       begin errors++; $display("FAIL three_len got %0d want 3", msg_len); end
    checks++; if (msg_header !== mk_hdr(8'd3)) begin errors++; $display("FAIL three_hdr got %h want %h", msg_header, mk_hdr(8'd3)); end
    msg_rdy = 1'b1;
    @(negedge clk);
    checks++; if (msg_val !== 1'b0) begin errors++; $display("FAIL three_consumed got %0b want 0", msg_val); end
    msg_rdy = 1'b0;
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < P; i++) exp[i] = 64'h100 + 64'(i);
    send(mk_hdr(8'd8));
    for (int i = 0; i < P; i++) send(exp[i]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (msg_val !== 1'b1 || noc2_in_rdy !== 1'b0 || msg_data !== exp || msg_len !== 8'd8) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got val=%0b rdy=%0b len=%0d data=%h want val=1 rdy=0 len=8 data=%h",
                 i, msg_val, noc2_in_rdy, msg_len, msg_data, exp);
      end
      noc2_in_val = 1'b1; noc2_in_data = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    end
    noc2_in_val = 1'b0;
    msg_rdy = 1'b1;
    @(negedge clk);
    msg_rdy = 1'b0;
    checks++; if (noc2_in_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_back got %0b want 1", noc2_in_rdy); end
    checks++; if (msg_val !== 1'b0)     begin errors++; $display("FAIL bp_val_drop got %0b want 0", msg_val); end
  endtask

  task automatic test_over_length;
    for (int i = 0; i < P; i++) exp[i] = 64'h200 + 64'(i);
    send(mk_hdr(8'd10));
    @(negedge clk);
    checks++; if (msg_err !== 1'b1) begin errors++; $display("FAIL ovl_err_set got %0b want 1", msg_err); end
    for (int i = 0; i < 9; i++) begin
      send(64'h200 + 64'(i));
      @(negedge clk);
      checks++; if (msg_val !== 1'b0) begin errors++; $display("FAIL ovl_early_val flit %0d got %0b want 0", i, msg_val); end
    end
    send(64'h209);
    @(negedge clk);
    checks++; if (msg_val !== 1'b1) begin errors++; $display("FAIL ovl_val got %0b want 1", msg_val); end
    checks++; if (msg_data !== exp) begin errors++; $display("FAIL ovl_data got %h want %h", msg_data, exp); end
    checks++; if (msg_len !== 8'd10) begin errors++; $display("FAIL ovl_len got %0d want 10", msg_len); end
    msg_rdy = 1'b1;
    send(64'h0);
    @(negedge clk);
    checks++; if (msg_val !== 1'b1 || msg_data !== '0) begin errors++; $display("FAIL ovl_next_msg got val=%0b data=%h want val=1 data=0", msg_val, msg_data); end
    checks++; if (msg_err !== 1'b1) begin errors++; $display("FAIL ovl_err_sticky got %0b want 1", msg_err); end
    @(negedge clk);
    msg_rdy = 1'b0;
  endtask

  task automatic test_reset_mid_pay;
    send(mk_hdr(8'd4));
    send(64'h11);
    send(64'h22);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (msg_err !== 1'b0)     begin errors++; $display("FAIL rmp_err got %0b want 0", msg_err); end
    checks++; if (msg_data !== '0)      begin errors++; $display("FAIL rmp_data got %h want 0", msg_data); end
    checks++; if (noc2_in_rdy !== 1'b1) begin errors++; $display("FAIL rmp_rdy got %0b want 1", noc2_in_rdy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (msg_val !== 1'b0) begin errors++; $display("FAIL rmp_no_val cyc %0d got %0b want 0", i, msg_val); end
    end
    exp = '0;
    exp[0] = 64'h0123_4567_89AB_CDEF;
    send(mk_hdr(8'd1));
    send(exp[0]);
    @(negedge clk);
    checks++; if (msg_val !== 1'b1)  begin errors++; $display("FAIL rmp_next_val got %0b want 1", msg_val); end
    checks++; if (msg_data !== exp)  begin errors++; $display("FAIL rmp_next_data got %h want %h", msg_data, exp); end
    checks++; if (msg_len !== 8'd1)  begin errors++; $display("FAIL rmp_next_len got %0d want 1", msg_len); end
    msg_rdy = 1'b1;
    @(negedge clk);
    msg_rdy = 1'b0;
  endtask

  task automatic test_bubbles;
    exp = '0;
    exp[0] = 64'hEEEE_0000_0000_0001;
    exp[1] = 64'hFFFF_0000_0000_0002;
    @(negedge clk); noc2_in_val = 1'b1; noc2_in_data = mk_hdr(8'd2);
    @(negedge clk); noc2_in_val = 1'b0; noc2_in_data = 64'h5555;
    @(negedge clk); noc2_in_val = 1'b0;
    @(negedge clk); noc2_in_val = 1'b1; noc2_in_data = exp[0];
    @(negedge clk); noc2_in_val = 1'b0; noc2_in_data = 64'h6666;
    checks++; if (msg_val !== 1'b0) begin errors++; $display("FAIL bub_early_val got %0b want 0", msg_val); end
    @(negedge clk); noc2_in_val = 1'b1; noc2_in_data = exp[1];
    @(negedge clk); noc2_in_val = 1'b0;
    checks++; if (msg_val !== 1'b1) begin errors++; $display("FAIL bub_val got %0b want 1", msg_val); end
    checks++; if (msg_data !== exp) begin errors++; $display("FAIL bub_data got %h want %h", msg_data, exp); end
    checks++; if (msg_header !== mk_hdr(8'd2)) begin errors++; $display("FAIL bub_hdr got %h want %h", msg_header, mk_hdr(8'd2)); end
    msg_rdy = 1'b1;
    @(negedge clk);
    msg_rdy = 1'b0;
  endtask

  initial begin
    noc2_in_val = 1'b0; noc2_in_data = '0; msg_rdy = 1'b0; rst = 1'b1;
    test_reset;
    test_zero_len;
    test_three_flit;
    test_backpressure;
    test_over_length;
    test_reset_mid_pay;
    test_bubbles;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
